// File: rtl/ct_lsu_cache_buffer_mentry.sv
// Multi-entry load cache buffer: keeps recent dcache line fragments returned at da,
// tagged by physical address, so later dc-stage loads can hit without a dcache read.
module ct_lsu_cache_buffer_mentry #(
  parameter int ENTRY_NUM  = 4,
  parameter int PA_WIDTH   = 40,
  parameter int OFFSET_W   = 4,
  parameter int DATA_WIDTH = 128,
  parameter int IDX_WIDTH  = 8,
  parameter int IDX_LSB    = 2
) (
  input  logic                           forever_cpuclk,
  input  logic                           cpurst,
  input  logic                           cp0_lsu_dcache_en,
  input  logic                           cp0_lsu_cb_aclr_dis,
  input  logic                           cp0_lsu_no_op_req,
  input  logic                           icc_idle,
  input  logic                           ld_dc_cb_addr_create_vld,
  input  logic [PA_WIDTH-OFFSET_W-1:0]   ld_dc_cb_addr_tto4,
  input  logic [PA_WIDTH-1:0]            ld_dc_addr1,
  input  logic                           ld_da_cb_data_vld,
  input  logic [DATA_WIDTH-1:0]          ld_da_cb_data,
  input  logic                           ld_da_cb_ld_inst_vld,
  input  logic                           ld_da_cb_ecc_cancel,
  input  logic                           lsu_dcache_ld_xx_gwen,
  input  logic [IDX_WIDTH-1:0]           dcache_idx,
  output logic                           cb_ld_dc_addr_hit,
  output logic [ENTRY_NUM-1:0]           cb_ld_dc_hit_vec,
  output logic [DATA_WIDTH-1:0]          cb_ld_da_data,
  output logic                           cb_ld_da_data_vld,
  output logic [ENTRY_NUM-1:0]           cb_vld_vec
);

  localparam int TAG_W = PA_WIDTH - OFFSET_W;
  localparam int PTR_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

  logic [ENTRY_NUM-1:0]  vld_q, vld_d;
  logic [ENTRY_NUM-1:0]  pend_q, pend_d;
  logic [ENTRY_NUM-1:0]  hit_q, hit_d;
  logic [PTR_W-1:0]      rr_q, rr_d;
  logic [TAG_W-1:0]      tag_q  [ENTRY_NUM];
  logic [DATA_WIDTH-1:0] data_q [ENTRY_NUM];

  logic                  flush_all;
  logic                  alloc_en;
  logic                  res_ok;
  logic [TAG_W-1:0]      lookup_tag;
  logic [ENTRY_NUM-1:0]  inv_vec;
  logic [ENTRY_NUM-1:0]  hit_vec;
  logic [ENTRY_NUM-1:0]  match_vec;
  logic [ENTRY_NUM-1:0]  free_vec;
  logic [ENTRY_NUM-1:0]  victim_vec;
  logic [ENTRY_NUM-1:0]  tag_we;
  logic [ENTRY_NUM-1:0]  data_we;
  logic                  use_rr;
  logic [PTR_W-1:0]      rr_idx;
  logic                  free_found;

  // The fill path is judged purely on data_vld; inst_vld and the line offset carry no extra meaning here.
  logic unused_inputs;
  assign unused_inputs = ld_da_cb_ld_inst_vld ^ (^ld_dc_addr1[OFFSET_W-1:0]);

  assign flush_all  = ~cp0_lsu_dcache_en | cp0_lsu_cb_aclr_dis | cp0_lsu_no_op_req | ~icc_idle;
  assign alloc_en   = ld_dc_cb_addr_create_vld & ~cp0_lsu_cb_aclr_dis & ~flush_all;
  assign res_ok     = ld_da_cb_data_vld & ~ld_da_cb_ecc_cancel & ~flush_all;
  assign lookup_tag = ld_dc_addr1[PA_WIDTH-1:OFFSET_W];

  generate
    for (genvar gi = 0; gi < ENTRY_NUM; gi++) begin : g_entry
      assign inv_vec[gi]   = lsu_dcache_ld_xx_gwen &
                             (tag_q[gi][IDX_LSB+IDX_WIDTH-1:IDX_LSB] == dcache_idx);
      assign hit_vec[gi]   = vld_q[gi] & (tag_q[gi] == lookup_tag) & ~inv_vec[gi] & ~flush_all;
      assign match_vec[gi] = vld_q[gi] & (tag_q[gi] == ld_dc_cb_addr_tto4);
      assign free_vec[gi]  = ~vld_q[gi] & ~pend_q[gi];
      assign tag_we[gi]    = alloc_en & victim_vec[gi];
      assign data_we[gi]   = pend_q[gi] & res_ok & ~inv_vec[gi];

      always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
          tag_q[gi]  <= '0;
          data_q[gi] <= '0;
        end else begin
          if (tag_we[gi])  tag_q[gi]  <= ld_dc_cb_addr_tto4;
          if (data_we[gi]) data_q[gi] <= ld_da_cb_data;
        end
      end
    end
  endgenerate

  // Victim: duplicate-tag reuse, else lowest free, else round-robin skipping the resolving entry.
  always_comb begin
    victim_vec = '0;
    use_rr     = 1'b0;
    rr_idx     = rr_q;
    free_found = 1'b0;
    if (|match_vec) begin
      victim_vec = match_vec;
    end else if (|free_vec) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (free_vec[i] && !free_found) begin
          victim_vec[i] = 1'b1;
          free_found    = 1'b1;
        end
      end
    end else begin
      use_rr = 1'b1;
      if (pend_q[rr_q]) rr_idx = rr_q + PTR_W'(1);
      victim_vec[rr_idx] = 1'b1;
    end
  end

  always_comb begin
    vld_d  = (vld_q & ~inv_vec) | data_we;
    pend_d = '0;
    rr_d   = rr_q;
    hit_d  = hit_vec;
    if (alloc_en) begin
      vld_d  = vld_d & ~victim_vec;
      pend_d = victim_vec;
      if (use_rr) rr_d = rr_idx + PTR_W'(1);
    end
    if (flush_all) begin
      vld_d  = '0;
      pend_d = '0;
      hit_d  = '0;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      vld_q  <= '0;
      pend_q <= '0;
      hit_q  <= '0;
      rr_q   <= '0;
    end else begin
      vld_q  <= vld_d;
      pend_q <= pend_d;
      hit_q  <= hit_d;
      rr_q   <= rr_d;
    end
  end

  always_comb begin
    cb_ld_da_data = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (hit_q[i]) cb_ld_da_data = cb_ld_da_data | data_q[i];
    end
  end

  assign cb_ld_da_data_vld = (|(hit_q & vld_q & ~inv_vec)) & ~flush_all;
  assign cb_ld_dc_addr_hit = |hit_vec;
  assign cb_ld_dc_hit_vec  = hit_vec;
  assign cb_vld_vec        = vld_q;

endmodule
